// File: rtl/mem_stage.sv
// Memory-access stage between EX and WB.
// Issues loads and stores to the dcache, aligns and extends load data, and handles LL.W/SC.W
// and misaligned-address exceptions. A combinational view of the instruction goes to ctrl.
module mem_stage #(
  parameter int unsigned ALE_SLOT  = 1,
  parameter logic [6:0]  ALE_CAUSE = 7'h09
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         ex_valid,
  input  logic [220:0] ex_mem_i,
  input  logic         llbit,
  output logic         dc_req_valid,
  input  logic         dc_req_ready,
  output logic         dc_req_we,
  output logic [31:0]  dc_req_addr,
  output logic [3:0]   dc_req_wstrb,
  output logic [31:0]  dc_req_wdata,
  input  logic         dc_resp_valid,
  input  logic [31:0]  dc_resp_rdata,
  output logic         pause_mem,
  output logic         wb_valid,
  output logic [118:0] mem_wb_o,
  output logic [105:0] mem_ctrl_o
);

  typedef struct packed {
    logic [31:0]     pc;
    logic [7:0]      aluop;
    logic            reg_write_en;
    logic [4:0]      reg_write_addr;
    logic [31:0]     reg_write_data;
    logic [31:0]     mem_addr;
    logic [31:0]     store_data;
    logic            csr_write_en;
    logic [13:0]     csr_addr;
    logic [31:0]     csr_write_data;
    logic [3:0]      is_exception;
    logic [3:0][6:0] exception_cause;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        reg_write_en;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        csr_write_en;
    logic [13:0] csr_addr;
    logic [31:0] csr_write_data;
    logic        llbit_write_en;
    logic        llbit_write_data;
  } mem_wb_t;

  typedef struct packed {
    logic [31:0]     pc;
    logic [7:0]      aluop;
    logic [3:0]      is_exception;
    logic [3:0][6:0] exception_cause;
    logic [31:0]     exception_addr;
    logic            is_ertn;
    logic            pause_mem;
  } mem_ctrl_t;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

  localparam logic [7:0] OpLdB  = 8'h20;
  localparam logic [7:0] OpLdH  = 8'h21;
  localparam logic [7:0] OpLdW  = 8'h22;
  localparam logic [7:0] OpStB  = 8'h23;
  localparam logic [7:0] OpStH  = 8'h24;
  localparam logic [7:0] OpStW  = 8'h25;
  localparam logic [7:0] OpLdBu = 8'h26;
  localparam logic [7:0] OpLdHu = 8'h27;
  localparam logic [7:0] OpLlW  = 8'h28;
  localparam logic [7:0] OpScW  = 8'h29;
  localparam logic [7:0] OpErtn = 8'h2A;

  localparam logic [1:0] AleIdx = ALE_SLOT[1:0];

  ex_mem_t         ex;
  mem_wb_t         wb_q;
  mem_wb_t         wb_next;
  mem_ctrl_t       ctrl;
  state_e          state;

  logic            op_byte, op_half, op_word;
  logic            is_ll, is_sc, is_load, is_store, is_mem;
  logic            is_wr_op, ale, exc_any, needs_dc;
  logic [3:0]      exc_vec;
  logic [3:0][6:0] cause_vec;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_data;

  assign ex         = ex_mem_i;
  assign mem_wb_o   = wb_q;
  assign mem_ctrl_o = ctrl;

  // Opcode decode
  assign op_byte  = (ex.aluop == OpLdB) | (ex.aluop == OpStB) | (ex.aluop == OpLdBu);
  assign op_half  = (ex.aluop == OpLdH) | (ex.aluop == OpStH) | (ex.aluop == OpLdHu);
  assign op_word  = (ex.aluop == OpLdW) | (ex.aluop == OpStW);
  assign is_ll    = (ex.aluop == OpLlW);
  assign is_sc    = (ex.aluop == OpScW);
  assign is_load  = (ex.aluop == OpLdB) | (ex.aluop == OpLdH) | (ex.aluop == OpLdW) |
                    (ex.aluop == OpLdBu) | (ex.aluop == OpLdHu) | is_ll;
  assign is_store = (ex.aluop == OpStB) | (ex.aluop == OpStH) | (ex.aluop == OpStW);
  assign is_mem   = is_load | is_store | is_sc;
  // Ops that finish as soon as the dcache accepts the request
  assign is_wr_op = is_store | is_sc;

  assign ale = (op_half & ex.mem_addr[0]) |
               ((op_word | is_ll | is_sc) & (ex.mem_addr[1:0] != 2'b00));

  // Merge the misaligned-address exception into the incoming exception vector
  always_comb begin
    exc_vec   = ex.is_exception;
    cause_vec = ex.exception_cause;
    if (ale) begin
      exc_vec[AleIdx]   = 1'b1;
      cause_vec[AleIdx] = ALE_CAUSE;
    end
  end

  assign exc_any  = |exc_vec;
  // SC.W without a valid reservation never touches memory
  assign needs_dc = ex_valid & is_mem & ~exc_any & ~(is_sc & ~llbit);

  // Load alignment and extension
  always_comb begin
    ld_byte = dc_resp_rdata[{ex.mem_addr[1:0], 3'b000} +: 8];
    ld_half = dc_resp_rdata[{ex.mem_addr[1], 4'b0000} +: 16];
    ld_data = dc_resp_rdata;
    if (ex.aluop == OpLdB) begin
      ld_data = {{24{ld_byte[7]}}, ld_byte};
    end else if (ex.aluop == OpLdBu) begin
      ld_data = {24'b0, ld_byte};
    end else if (ex.aluop == OpLdH) begin
      ld_data = {{16{ld_half[15]}}, ld_half};
    end else if (ex.aluop == OpLdHu) begin
      ld_data = {16'b0, ld_half};
    end
  end

  // Dcache request: store data is replicated so the strobes select the lane
  always_comb begin
    dc_req_valid = (state == StReq) & ~flush;
    dc_req_we    = is_wr_op;
    dc_req_addr  = ex.mem_addr;
    dc_req_wstrb = 4'b0000;
    dc_req_wdata = ex.store_data;
    if (is_wr_op) begin
      if (op_byte) begin
        dc_req_wstrb = 4'b0001 << ex.mem_addr[1:0];
        dc_req_wdata = {4{ex.store_data[7:0]}};
      end else if (op_half) begin
        dc_req_wstrb = 4'b0011 << {ex.mem_addr[1], 1'b0};
        dc_req_wdata = {2{ex.store_data[15:0]}};
      end else begin
        dc_req_wstrb = 4'hF;
      end
    end
  end

  // Writeback bundle for the current instruction; enables are killed on any exception
  always_comb begin
    wb_next                  = '0;
    wb_next.pc               = ex.pc;
    wb_next.reg_write_en     = ex.reg_write_en;
    wb_next.reg_write_addr   = ex.reg_write_addr;
    wb_next.reg_write_data   = ex.reg_write_data;
    wb_next.csr_write_en     = ex.csr_write_en;
    wb_next.csr_addr         = ex.csr_addr;
    wb_next.csr_write_data   = ex.csr_write_data;
    if (is_load) begin
      wb_next.reg_write_data = ld_data;
    end
    if (is_ll) begin
      wb_next.llbit_write_en   = 1'b1;
      wb_next.llbit_write_data = 1'b1;
    end
    if (is_sc) begin
      wb_next.reg_write_data   = {31'b0, llbit};
      wb_next.llbit_write_en   = llbit;
      wb_next.llbit_write_data = 1'b0;
    end
    if (exc_any) begin
      wb_next.reg_write_en   = 1'b0;
      wb_next.csr_write_en   = 1'b0;
      wb_next.llbit_write_en = 1'b0;
    end
  end

  // Stall EX whenever the held instruction still needs this stage
  always_comb begin
    pause_mem = 1'b0;
    unique case (state)
      StIdle:  pause_mem = needs_dc & ~flush;
      StReq:   pause_mem = ~flush & ~(dc_req_ready & is_wr_op);
      StWait:  pause_mem = ~dc_resp_valid;
      StDrain: pause_mem = ex_valid & is_mem;
      default: pause_mem = 1'b0;
    endcase
  end

  // Instruction view for exception/ertn arbitration in ctrl
  always_comb begin
    ctrl = '0;
    if (ex_valid) begin
      ctrl.pc              = ex.pc;
      ctrl.aluop           = ex.aluop;
      ctrl.is_exception    = exc_vec;
      ctrl.exception_cause = cause_vec;
      ctrl.exception_addr  = ex.mem_addr;
      ctrl.is_ertn         = (ex.aluop == OpErtn);
      ctrl.pause_mem       = pause_mem;
    end
  end

  // Stage FSM with registered writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      wb_valid <= 1'b0;
      wb_q     <= '0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (ex_valid && !flush) begin
            if (needs_dc) begin
              state <= StReq;
            end else begin
              wb_valid <= 1'b1;
              wb_q     <= wb_next;
            end
          end
        end
        StReq: begin
          if (flush) begin
            state <= StIdle;
          end else if (dc_req_ready) begin
            if (is_wr_op) begin
              wb_valid <= 1'b1;
              wb_q     <= wb_next;
              state    <= StIdle;
            end else begin
              state <= StWait;
            end
          end
        end
        StWait: begin
          // A response coinciding with flush belongs to the killed load: drop it here
          if (dc_resp_valid) begin
            state <= StIdle;
            if (!flush) begin
              wb_valid <= 1'b1;
              wb_q     <= wb_next;
            end
          end else if (flush) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          if (dc_resp_valid) begin
            state <= StIdle;
          end
          // Non-memory ops are not stalled here, so they must retire
          if (ex_valid && !flush && !is_mem) begin
            wb_valid <= 1'b1;
            wb_q     <= wb_next;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  typedef struct packed {
    logic [31:0]     pc;
    logic [7:0]      aluop;
    logic            reg_write_en;
    logic [4:0]      reg_write_addr;
    logic [31:0]     reg_write_data;
    logic [31:0]     mem_addr;
    logic [31:0]     store_data;
    logic            csr_write_en;
    logic [13:0]     csr_addr;
    logic [31:0]     csr_write_data;
    logic [3:0]      is_exception;
    logic [3:0][6:0] exception_cause;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        reg_write_en;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        csr_write_en;
    logic [13:0] csr_addr;
    logic [31:0] csr_write_data;
    logic        llbit_write_en;
    logic        llbit_write_data;
  } mem_wb_t;

  typedef struct packed {
    logic [31:0]     pc;
    logic [7:0]      aluop;
    logic [3:0]      is_exception;
    logic [3:0][6:0] exception_cause;
    logic [31:0]     exception_addr;
    logic            is_ertn;
    logic            pause_mem;
  } mem_ctrl_t;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         ex_valid;
  logic [220:0] ex_mem_i;
  logic         llbit;
  logic         dc_req_valid;
  logic         dc_req_ready;
  logic         dc_req_we;
  logic [31:0]  dc_req_addr;
  logic [3:0]   dc_req_wstrb;
  logic [31:0]  dc_req_wdata;
  logic         dc_resp_valid;
  logic [31:0]  dc_resp_rdata;
  logic         pause_mem;
  logic         wb_valid;
  logic [118:0] mem_wb_o;
  logic [105:0] mem_ctrl_o;

  ex_mem_t   ex;
  mem_wb_t   wb;
  mem_ctrl_t ctl;

  int vectors     = 0;
  int miscompares = 0;
  int wb_cnt      = 0;
  int pcnt        = 0;

  assign ex_mem_i = ex;
  assign wb       = mem_wb_o;
  assign ctl      = mem_ctrl_o;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_mem_i      (ex_mem_i),
    .llbit         (llbit),
    .dc_req_valid  (dc_req_valid),
    .dc_req_ready  (dc_req_ready),
    .dc_req_we     (dc_req_we),
    .dc_req_addr   (dc_req_addr),
    .dc_req_wstrb  (dc_req_wstrb),
    .dc_req_wdata  (dc_req_wdata),
    .dc_resp_valid (dc_resp_valid),
    .dc_resp_rdata (dc_resp_rdata),
    .pause_mem     (pause_mem),
    .wb_valid      (wb_valid),
    .mem_wb_o      (mem_wb_o),
    .mem_ctrl_o    (mem_ctrl_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wb_cnt += int'(wb_valid);
  endtask

  task automatic set_ex(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata);
    ex                = '0;
    ex.pc             = 32'h1c00_0100;
    ex.aluop          = op;
    ex.reg_write_en   = 1'b1;
    ex.reg_write_addr = 5'd4;
    ex.reg_write_data = rdata;
    ex.mem_addr       = addr;
    ex.store_data     = sdata;
  endtask

  // Load already presented in IDLE: accept at once, respond one cycle later
  task automatic load_txn(input string tag, input logic [31:0] rdata);
    ex_valid = 1'b1;
    #1;
    chk1({tag, "_idle_pause"}, pause_mem, 1'b1);
    tick();
    chk1({tag, "_req_valid"}, dc_req_valid, 1'b1);
    chk1({tag, "_req_we"}, dc_req_we, 1'b0);
    chk({tag, "_req_addr"}, dc_req_addr, ex.mem_addr);
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready  = 1'b0;
    dc_resp_valid = 1'b1;
    dc_resp_rdata = rdata;
    #1;
    chk1({tag, "_wait_pause"}, pause_mem, 1'b0);
    tick();
    dc_resp_valid = 1'b0;
    ex_valid      = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    ex_valid      = 1'b0;
    llbit         = 1'b0;
    dc_req_ready  = 1'b0;
    dc_resp_valid = 1'b0;
    dc_resp_rdata = '0;
    ex            = '0;
    tick();
    tick();
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_pause", pause_mem, 1'b0);
    chk1("rst_req_valid", dc_req_valid, 1'b0);
    chk1("rst_wb_zero", |mem_wb_o, 1'b0);
    chk1("rst_ctrl_zero", |mem_ctrl_o, 1'b0);
    rst = 1'b0;
    tick();

    // ADD: completes in one cycle, CSR fields pass through
    set_ex(8'h10, 32'h0, 32'h0, 32'h5);
    ex.csr_write_en   = 1'b1;
    ex.csr_addr       = 14'h123;
    ex.csr_write_data = 32'hCAFE_0001;
    ex_valid = 1'b1;
    #1;
    chk1("add_pause", pause_mem, 1'b0);
    chk1("add_req", dc_req_valid, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk1("add_wb_valid", wb_valid, 1'b1);
    chk1("add_wb_we", wb.reg_write_en, 1'b1);
    chk("add_wb_data", wb.reg_write_data, 32'h5);
    chk("add_csr_data", wb.csr_write_data, 32'hCAFE_0001);
    chk("add_csr_addr", {18'b0, wb.csr_addr}, 32'h123);
    tick();
    chk1("add_wb_once", wb_valid, 1'b0);

    // Flush beats completion
    flush    = 1'b1;
    ex_valid = 1'b1;
    tick();
    flush    = 1'b0;
    ex_valid = 1'b0;
    chk1("flush_prio_wb", wb_valid, 1'b0);

    // LD.B / LD.BU from the top byte lane
    set_ex(8'h20, 32'h1003, 32'h0, 32'h0);
    load_txn("ldb", 32'h8000_0000);
    chk1("ldb_wb_valid", wb_valid, 1'b1);
    chk("ldb_data", wb.reg_write_data, 32'hFFFF_FF80);
    set_ex(8'h26, 32'h1003, 32'h0, 32'h0);
    load_txn("ldbu", 32'h8000_0000);
    chk("ldbu_data", wb.reg_write_data, 32'h0000_0080);
    set_ex(8'h21, 32'h1002, 32'h0, 32'h0);
    load_txn("ldh", 32'h9ABC_0000);
    chk("ldh_data", wb.reg_write_data, 32'hFFFF_9ABC);

    // ST.H with ready held off for three cycles
    set_ex(8'h24, 32'h1002, 32'hABCD_1234, 32'h0);
    ex_valid = 1'b1;
    pcnt     = 0;
    wb_cnt   = 0;
    for (int c = 0; c < 6; c++) begin
      dc_req_ready = (c == 3);
      #1;
      pcnt += int'(pause_mem);
      if (c == 1) begin
        chk1("sth_req_valid", dc_req_valid, 1'b1);
        chk1("sth_we", dc_req_we, 1'b1);
        chk("sth_wstrb", {28'b0, dc_req_wstrb}, 32'hC);
        chk("sth_wdata", dc_req_wdata, 32'h1234_1234);
      end
      tick();
      if (wb_valid) ex_valid = 1'b0;
    end
    dc_req_ready = 1'b0;
    chk("sth_pause_cycles", pcnt, 32'd3);
    chk("sth_wb_count", wb_cnt, 32'd1);

    // ST.B lane select
    set_ex(8'h23, 32'h2001, 32'h0000_00A5, 32'h0);
    ex_valid = 1'b1;
    tick();
    chk("stb_wstrb", {28'b0, dc_req_wstrb}, 32'h2);
    chk("stb_wdata", dc_req_wdata, 32'hA5A5_A5A5);
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    ex_valid     = 1'b0;
    chk1("stb_wb_valid", wb_valid, 1'b1);

    // Misaligned LD.W raises ALE and skips the dcache
    set_ex(8'h22, 32'h1001, 32'h0, 32'h0);
    ex_valid = 1'b1;
    #1;
    chk1("ale_exc_bit", ctl.is_exception[1], 1'b1);
    chk("ale_cause", {25'b0, ctl.exception_cause[1]}, 32'h09);
    chk("ale_addr", ctl.exception_addr, 32'h1001);
    chk1("ale_req", dc_req_valid, 1'b0);
    chk1("ale_pause", pause_mem, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk1("ale_wb_valid", wb_valid, 1'b1);
    chk1("ale_wb_we", wb.reg_write_en, 1'b0);
    tick();
    chk1("ale_no_req", dc_req_valid, 1'b0);

    // Exception from EX on ST.W: no request, writes suppressed
    set_ex(8'h25, 32'h3000, 32'h1, 32'h0);
    ex.is_exception       = 4'b0001;
    ex.exception_cause[0] = 7'h02;
    ex.csr_write_en       = 1'b1;
    ex_valid = 1'b1;
    #1;
    chk1("exin_req", dc_req_valid, 1'b0);
    chk1("exin_pause", pause_mem, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk1("exin_wb_valid", wb_valid, 1'b1);
    chk1("exin_csr_we", wb.csr_write_en, 1'b0);

    // ERTN flagged to ctrl
    set_ex(8'h2A, 32'h0, 32'h0, 32'h0);
    ex_valid = 1'b1;
    #1;
    chk1("ertn_flag", ctl.is_ertn, 1'b1);
    tick();
    ex_valid = 1'b0;
    chk1("ertn_wb_valid", wb_valid, 1'b1);

    // LL.W then SC.W with and without reservation
    set_ex(8'h28, 32'h2000, 32'h0, 32'h0);
    load_txn("ll", 32'hDEAD_BEEF);
    chk("ll_data", wb.reg_write_data, 32'hDEAD_BEEF);
    chk1("ll_llbit_we", wb.llbit_write_en, 1'b1);
    chk1("ll_llbit_data", wb.llbit_write_data, 1'b1);
    llbit = 1'b1;
    set_ex(8'h29, 32'h2000, 32'h0000_55AA, 32'h0);
    ex_valid = 1'b1;
    #1;
    chk1("sc1_idle_pause", pause_mem, 1'b1);
    tick();
    chk1("sc1_req_valid", dc_req_valid, 1'b1);
    chk1("sc1_we", dc_req_we, 1'b1);
    chk("sc1_wstrb", {28'b0, dc_req_wstrb}, 32'hF);
    chk("sc1_wdata", dc_req_wdata, 32'h0000_55AA);
    dc_req_ready = 1'b1;
    #1;
    chk1("sc1_pause_release", pause_mem, 1'b0);
    tick();
    dc_req_ready = 1'b0;
    ex_valid     = 1'b0;
    chk1("sc1_wb_valid", wb_valid, 1'b1);
    chk("sc1_rd", wb.reg_write_data, 32'h1);
    chk1("sc1_llbit_we", wb.llbit_write_en, 1'b1);
    chk1("sc1_llbit_data", wb.llbit_write_data, 1'b0);
    llbit = 1'b0;
    ex_valid = 1'b1;
    #1;
    chk1("sc0_req", dc_req_valid, 1'b0);
    chk1("sc0_pause", pause_mem, 1'b0);
    tick();
    ex_valid = 1'b0;
    chk1("sc0_wb_valid", wb_valid, 1'b1);
    chk("sc0_rd", wb.reg_write_data, 32'h0);
    chk1("sc0_llbit_we", wb.llbit_write_en, 1'b0);
    tick();
    chk1("sc0_no_req", dc_req_valid, 1'b0);

    // Flush in REQ drops the request
    set_ex(8'h25, 32'h4000, 32'h7, 32'h0);
    ex_valid = 1'b1;
    tick();
    flush        = 1'b1;
    dc_req_ready = 1'b1;
    #1;
    chk1("flreq_req_valid", dc_req_valid, 1'b0);
    tick();
    flush        = 1'b0;
    dc_req_ready = 1'b0;
    ex_valid     = 1'b0;
    chk1("flreq_wb_valid", wb_valid, 1'b0);
    tick();
    chk1("flreq_idle_req", dc_req_valid, 1'b0);

    // Flush in WAIT: stale response drained, next load returns its own data
    wb_cnt = 0;
    set_ex(8'h22, 32'h3000, 32'h0, 32'h0);
    ex_valid = 1'b1;
    tick();
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    flush        = 1'b1;
    tick();
    flush    = 1'b0;
    ex_valid = 1'b0;
    tick();
    set_ex(8'h22, 32'h3004, 32'h0, 32'h0);
    ex_valid = 1'b1;
    #1;
    chk1("drain_pause", pause_mem, 1'b1);
    tick();
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'hBAD0_BAD0;
    #1;
    chk1("drain_resp_pause", pause_mem, 1'b1);
    tick();
    dc_resp_valid = 1'b0;
    chk1("drain_no_wb", wb_valid, 1'b0);
    load_txn("reload", 32'h600D_F00D);
    chk1("reload_wb_valid", wb_valid, 1'b1);
    chk("reload_data", wb.reg_write_data, 32'h600D_F00D);
    chk("flush_wb_count", wb_cnt, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
